// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Merges the core's instruction-fetch port and LSU data port onto
//               one shared memory port. Every accepted request pushes a 1-bit
//               source tag into an in-order FIFO; each returning response pops
//               the head tag and is steered back to the port that issued it.
//               Grant is fixed data-over-inst priority by default. A request
//               that is presented but stalled keeps its grant until it is
//               accepted or withdrawn.
//               Optional macro MEM_ARB_RR_EN: round-robin tie-break using a
//               last_grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MaxOutLog2 = 2,
  parameter int Xlen       = 32,
  parameter int MaskBits   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // Instruction-fetch port
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic [Xlen-1:0]     inst_addr_i,
  input  logic [Xlen-1:0]     inst_wdata_i,
  input  logic [MaskBits-1:0] inst_wmask_i,
  output logic [Xlen-1:0]     inst_rdata_o,
  output logic                inst_rvalid_o,
  // LSU data port
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [Xlen-1:0]     data_addr_i,
  input  logic [Xlen-1:0]     data_wdata_i,
  input  logic [MaskBits-1:0] data_wmask_i,
  output logic [Xlen-1:0]     data_rdata_o,
  output logic                data_rvalid_o,
  // Shared downstream memory port
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i
);

  localparam int Depth = 2 ** MaxOutLog2;
  localparam int CntW  = MaxOutLog2 + 1;

  // Source tag encoding
  localparam logic TagInst = 1'b0;
  localparam logic TagData = 1'b1;

  // Tag FIFO state
  logic [MaxOutLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [MaxOutLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [Depth-1:0]      tag_q, tag_d;

  // Grant lock for a stalled request
  logic lock_q, lock_d;
  logic lock_port_q, lock_port_d;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  logic full;
  logic empty;
  logic grant;
  logic grant_valid;
  logic issue;
  logic push;
  logic pop;
  logic head_tag;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign head_tag = tag_q[rd_ptr_q];

  // Grant selection: a live lock wins, otherwise arbitrate among valid ports
  always_comb begin
    grant = TagInst;
    if (lock_q && (lock_port_q ? data_valid_i : inst_valid_i)) begin
      grant = lock_port_q;
    end else if (inst_valid_i && data_valid_i) begin
`ifdef MEM_ARB_RR_EN
      grant = ~last_grant_q;
`else
      grant = TagData;
`endif
    end else if (data_valid_i) begin
      grant = TagData;
    end else begin
      grant = TagInst;
    end
  end

  // Issue and handshake qualification; outputs are held low during reset
  assign grant_valid = (grant == TagData) ? data_valid_i : inst_valid_i;
  assign issue       = grant_valid && !full && !rst_i;
  assign push        = issue && mem_ready_i;
  assign pop         = mem_rvalid_i && !empty && !rst_i;

  // Request mux toward memory
  assign mem_valid_o  = issue;
  assign mem_addr_o   = (grant == TagData) ? data_addr_i  : inst_addr_i;
  assign mem_wdata_o  = (grant == TagData) ? data_wdata_i : inst_wdata_i;
  assign mem_wmask_o  = (grant == TagData) ? data_wmask_i : inst_wmask_i;
  assign inst_ready_o = push && (grant == TagInst);
  assign data_ready_o = push && (grant == TagData);

  // Response routing: data broadcast, rvalid steered by the head tag
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign inst_rvalid_o = pop && (head_tag == TagInst);
  assign data_rvalid_o = pop && (head_tag == TagData);

  // Next-state for FIFO, lock and round-robin history
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_d       = tag_q;
    lock_d      = issue && !mem_ready_i;
    lock_port_d = grant;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = grant;
    end
`endif
    if (push) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = wr_ptr_q + MaxOutLog2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + MaxOutLog2'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= TagInst;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= TagInst;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
`default_nettype wire
